// File: rtl/wb_pkg.sv
// wb_pkg: shared state encodings and default widths for the Wishbone master bridge.
package wb_pkg;
  typedef enum logic [1:0] {WB_IDLE = 2'b00, WB_BUSY = 2'b01, WB_HOLD = 2'b10} wb_state_e;
  localparam int WB_DW = 32;
  localparam int WB_AW = 32;
  localparam int WB_SW = 6;
endpackage

// File: rtl/wb_master_if_p_if.sv
// wb_master_if_p_if: Wishbone B3 classic bus signals between master bridge and arbiter.
interface wb_master_if_p_if
  import wb_pkg::*;
#(
  parameter int DW = WB_DW,
  parameter int AW = WB_AW
);
  logic [DW-1:0]   wishbone_data_i;
  logic            wishbone_ack_i;
  logic            wishbone_err_i;
  logic [AW-1:0]   wishbone_addr_o;
  logic [DW-1:0]   wishbone_data_o;
  logic            wishbone_we_o;
  logic [DW/8-1:0] wishbone_sel_o;
  logic            wishbone_stb_o;
  logic            wishbone_cyc_o;
  modport master (
    input  wishbone_data_i, wishbone_ack_i, wishbone_err_i,
    output wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o, wishbone_stb_o, wishbone_cyc_o
  );
  modport slave (
    output wishbone_data_i, wishbone_ack_i, wishbone_err_i,
    input  wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o, wishbone_stb_o, wishbone_cyc_o
  );
endinterface

// File: rtl/wb_watchdog.sv
// wb_watchdog: saturating cycle counter that flags a bus access stuck for TIMEOUT cycles.
module wb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else      cnt <= clear ? '0 : (enable && cnt != '1) ? cnt + TW'(1) : cnt;
  assign expired = (TIMEOUT != 0) && (cnt == LAST);
endmodule

// File: rtl/wb_master_if_p.sv
// wb_master_if_p: parametrised Wishbone B3 classic single-access master bridge
// with ERR/timeout reporting and a read-data hold buffer for stalled pipelines.
module wb_master_if_p
  import wb_pkg::*;
#(
  parameter int DW      = WB_DW,
  parameter int AW      = WB_AW,
  parameter int SW      = WB_SW,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW-1:0]   stall_i,
  input  logic            flush_i,
  input  logic            cpu_ce_i,
  input  logic            cpu_we_i,
  input  logic [AW-1:0]   cpu_addr_i,
  input  logic [DW-1:0]   cpu_data_i,
  input  logic [DW/8-1:0] cpu_sel_i,
  output logic [DW-1:0]   cpu_data_o,
  output logic            cpu_err_o,
  output logic            stallreq,
  wb_master_if_p_if.master wb
);
  wb_state_e state_q, state_d;
  logic [AW-1:0]   adr_q;
  logic [DW-1:0]   dat_q, rd_buf;
  logic [DW/8-1:0] sel_q;
  logic we_q, cyc_q, err_buf;
  logic busy, hold, start, err_c, ack_c, done, abort, wd_en, hold_exit, expired;
  wb_watchdog #(.TIMEOUT(TIMEOUT), .TW(TW)) u_wd (
    .clk, .rst, .clear(start), .enable(wd_en), .expired
  );
  // rst gates start so every combinational output reads 0 while reset is held
  always_comb begin
    busy       = state_q == WB_BUSY;
    hold       = state_q == WB_HOLD;
    start      = state_q == WB_IDLE && cpu_ce_i && !flush_i && rst;
    err_c      = busy && (wb.wishbone_err_i || expired);
    ack_c      = busy && wb.wishbone_ack_i && !err_c;
    done       = err_c || ack_c;
    abort      = busy && flush_i && !done;
    wd_en      = busy && !done && !flush_i;
    hold_exit  = stall_i == '0 || flush_i;
    stallreq   = start || wd_en;
    cpu_err_o  = err_c || (hold && err_buf);
    cpu_data_o = (ack_c && !we_q) ? wb.wishbone_data_i : hold ? rd_buf : '0;
    state_d    = start ? WB_BUSY :
                 done  ? (hold_exit ? WB_IDLE : WB_HOLD) :
                 abort ? WB_IDLE :
                 (hold && hold_exit) ? WB_IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= WB_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      rd_buf  <= '0;
      err_buf <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= start ? cpu_addr_i : (done || abort) ? '0 : adr_q;
      dat_q   <= start ? cpu_data_i : (done || abort) ? '0 : dat_q;
      sel_q   <= start ? cpu_sel_i  : (done || abort) ? '0 : sel_q;
      we_q    <= start ? cpu_we_i   : (done || abort) ? 1'b0 : we_q;
      cyc_q   <= start ? 1'b1       : (done || abort) ? 1'b0 : cyc_q;
      if (done) begin
        rd_buf  <= cpu_data_o;
        err_buf <= err_c;
      end
    end
  assign wb.wishbone_addr_o = adr_q;
  assign wb.wishbone_data_o = dat_q;
  assign wb.wishbone_sel_o  = sel_q;
  assign wb.wishbone_we_o   = we_q;
  assign wb.wishbone_stb_o  = cyc_q;
  assign wb.wishbone_cyc_o  = cyc_q;
endmodule

// File: tb/tb_wb_master_if_p.sv
// tb_wb_master_if_p: directed table-driven bench for the Wishbone master bridge.
module tb_wb_master_if_p;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;

  logic [5:0]  st;
  logic        fl, ce, we, a_err, a_sr;
  logic [31:0] ad, wd, a_cd;
  logic [3:0]  se;
  wb_master_if_p_if #(.DW(32), .AW(32)) bus_a ();
  wb_master_if_p #(.DW(32), .AW(32), .SW(6), .TIMEOUT(255), .TW(8)) dut_a (
    .clk, .rst, .stall_i(st), .flush_i(fl), .cpu_ce_i(ce), .cpu_we_i(we),
    .cpu_addr_i(ad), .cpu_data_i(wd), .cpu_sel_i(se), .cpu_data_o(a_cd),
    .cpu_err_o(a_err), .stallreq(a_sr), .wb(bus_a)
  );

  logic [5:0]  b_st;
  logic        b_fl, b_ce, b_we, b_err, b_sr;
  logic [39:0] b_ad;
  logic [63:0] b_wd, b_cd;
  logic [7:0]  b_se;
  wb_master_if_p_if #(.DW(64), .AW(40)) bus_b ();
  wb_master_if_p #(.DW(64), .AW(40), .SW(6), .TIMEOUT(4), .TW(8)) dut_b (
    .clk, .rst, .stall_i(b_st), .flush_i(b_fl), .cpu_ce_i(b_ce), .cpu_we_i(b_we),
    .cpu_addr_i(b_ad), .cpu_data_i(b_wd), .cpu_sel_i(b_se), .cpu_data_o(b_cd),
    .cpu_err_o(b_err), .stallreq(b_sr), .wb(bus_b)
  );

  typedef struct {
    logic ce, we, fl; logic [5:0] st; logic [31:0] ad, wd; logic [3:0] se;
    logic ak, er; logic [31:0] rd;
    logic x_sr; logic [31:0] x_cd; logic x_er, x_cyc; logic [31:0] x_ad;
    logic x_we; logic [3:0] x_se; logic [31:0] x_wd;
  } vec_t;
  vec_t v[30];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    v[0]  = '{1,0,0,0,'h100,0,'hf,0,0,0,                    1,0,0,0,0,0,0,0};
    v[1]  = '{0,0,0,0,'h100,0,'hf,1,0,'hDEADBEEF,           0,'hDEADBEEF,0,1,'h100,0,'hf,0};
    v[2]  = '{0,0,0,0,0,0,0,0,0,0,                          0,0,0,0,0,0,0,0};
    v[3]  = '{1,1,0,0,'h204,'h12345678,3,0,0,0,             1,0,0,0,0,0,0,0};
    for (int i = 4; i < 7; i++)
      v[i] = '{1,1,0,0,'h204,'h12345678,3,0,0,0,            1,0,0,1,'h204,1,3,'h12345678};
    v[7]  = '{1,1,0,0,'h204,'h12345678,3,1,0,'hFFFFFFFF,    0,0,0,1,'h204,1,3,'h12345678};
    v[8]  = '{0,0,0,0,0,0,0,0,0,0,                          0,0,0,0,0,0,0,0};
    v[9]  = '{1,0,0,0,'h300,0,'hf,0,0,0,                    1,0,0,0,0,0,0,0};
    v[10] = '{1,0,0,3,'h300,0,'hf,1,0,'hA5A5A5A5,           0,'hA5A5A5A5,0,1,'h300,0,'hf,0};
    for (int i = 11; i < 14; i++)
      v[i] = '{1,0,0,3,'h300,0,'hf,0,0,0,                   0,'hA5A5A5A5,0,0,0,0,0,0};
    v[14] = '{0,0,0,0,0,0,0,0,0,0,                          0,'hA5A5A5A5,0,0,0,0,0,0};
    v[15] = '{0,0,0,0,0,0,0,1,0,'h77777777,                 0,0,0,0,0,0,0,0};
    v[16] = '{1,0,0,0,'h400,0,'hf,0,0,0,                    1,0,0,0,0,0,0,0};
    v[17] = '{1,0,0,0,'h400,0,'hf,0,0,0,                    1,0,0,1,'h400,0,'hf,0};
    v[18] = '{1,0,0,0,'h400,0,'hf,0,1,'h11111111,           0,0,1,1,'h400,0,'hf,0};
    v[19] = '{0,0,0,0,0,0,0,0,0,0,                          0,0,0,0,0,0,0,0};
    v[20] = '{1,0,0,0,'h500,0,'hf,0,0,0,                    1,0,0,0,0,0,0,0};
    v[21] = '{1,0,0,1,'h500,0,'hf,1,1,'h22222222,           0,0,1,1,'h500,0,'hf,0};
    v[22] = '{0,0,0,1,0,0,0,0,0,0,                          0,0,1,0,0,0,0,0};
    v[23] = '{0,0,1,1,0,0,0,0,0,0,                          0,0,1,0,0,0,0,0};
    v[24] = '{0,0,0,0,0,0,0,0,0,0,                          0,0,0,0,0,0,0,0};
    v[25] = '{1,0,0,0,'h600,0,'hf,0,0,0,                    1,0,0,0,0,0,0,0};
    v[26] = '{1,0,0,0,'h600,0,'hf,0,0,0,                    1,0,0,1,'h600,0,'hf,0};
    v[27] = '{1,0,1,0,'h600,0,'hf,0,0,0,                    0,0,0,1,'h600,0,'hf,0};
    v[28] = '{1,0,1,0,'h600,0,'hf,0,0,0,                    0,0,0,0,0,0,0,0};
    v[29] = '{0,0,0,0,0,0,0,0,0,0,                          0,0,0,0,0,0,0,0};

    {ce, we, fl, st, ad, wd, se} = '0;
    bus_a.wishbone_ack_i = 0; bus_a.wishbone_err_i = 0; bus_a.wishbone_data_i = 0;
    {b_ce, b_we, b_fl, b_st, b_ad, b_wd, b_se} = '0;
    bus_b.wishbone_ack_i = 0; bus_b.wishbone_err_i = 0; bus_b.wishbone_data_i = 0;
    ce = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.cyc", bus_a.wishbone_cyc_o, 0);
    chk("rst.stb", bus_a.wishbone_stb_o, 0);
    chk("rst.adr", bus_a.wishbone_addr_o, 0);
    chk("rst.sr",  a_sr, 0);
    chk("rst.cd",  a_cd, 0);
    chk("rst.err", a_err, 0);
    ce = 0;
    @(negedge clk) rst = 1;
    @(posedge clk) #1;

    for (int i = 0; i < 30; i++) begin
      ce = v[i].ce; we = v[i].we; fl = v[i].fl; st = v[i].st;
      ad = v[i].ad; wd = v[i].wd; se = v[i].se;
      bus_a.wishbone_ack_i = v[i].ak; bus_a.wishbone_err_i = v[i].er;
      bus_a.wishbone_data_i = v[i].rd;
      @(negedge clk);
      chk($sformatf("r%0d.sr", i),  a_sr,  v[i].x_sr);
      chk($sformatf("r%0d.cd", i),  a_cd,  v[i].x_cd);
      chk($sformatf("r%0d.err", i), a_err, v[i].x_er);
      chk($sformatf("r%0d.cyc", i), bus_a.wishbone_cyc_o, v[i].x_cyc);
      chk($sformatf("r%0d.stb", i), bus_a.wishbone_stb_o, v[i].x_cyc);
      chk($sformatf("r%0d.adr", i), bus_a.wishbone_addr_o, v[i].x_ad);
      chk($sformatf("r%0d.we", i),  bus_a.wishbone_we_o, v[i].x_we);
      chk($sformatf("r%0d.sel", i), bus_a.wishbone_sel_o, v[i].x_se);
      chk($sformatf("r%0d.wdo", i), bus_a.wishbone_data_o, v[i].x_wd);
      @(posedge clk) #1;
    end
    {ce, we, fl, st, ad, wd, se} = '0;
    bus_a.wishbone_ack_i = 0; bus_a.wishbone_err_i = 0;

    // asynchronous reset in the middle of a bus cycle
    ce = 1; ad = 32'h700; se = 4'hf;
    @(posedge clk) #1;
    chk("arst.busy_cyc", bus_a.wishbone_cyc_o, 1);
    chk("arst.busy_sr", a_sr, 1);
    #2 rst = 0;
    #1;
    chk("arst.cyc", bus_a.wishbone_cyc_o, 0);
    chk("arst.stb", bus_a.wishbone_stb_o, 0);
    chk("arst.adr", bus_a.wishbone_addr_o, 0);
    chk("arst.sel", bus_a.wishbone_sel_o, 0);
    chk("arst.sr",  a_sr, 0);
    chk("arst.cd",  a_cd, 0);
    ce = 0;
    @(negedge clk) rst = 1;
    @(posedge clk) #1;

    // 64-bit data / 40-bit address read
    b_ce = 1; b_ad = 40'h12_3456_7890; b_se = 8'hA5;
    @(negedge clk) chk("w64.sr_req", b_sr, 1);
    @(posedge clk) #1;
    b_ce = 0;
    bus_b.wishbone_ack_i = 1; bus_b.wishbone_data_i = 64'h0123456789ABCDEF;
    @(negedge clk);
    chk("w64.cd",  b_cd, 64'h0123456789ABCDEF);
    chk("w64.sel", bus_b.wishbone_sel_o, 8'hA5);
    chk("w64.adr", bus_b.wishbone_addr_o, 40'h12_3456_7890);
    chk("w64.sr",  b_sr, 0);
    @(posedge clk) #1;
    bus_b.wishbone_ack_i = 0;
    chk("w64.cyc_end", bus_b.wishbone_cyc_o, 0);

    // watchdog abort with TIMEOUT=4 and a silent slave
    b_ce = 1; b_ad = 40'h80;
    @(posedge clk) #1;
    b_ce = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("to%0d.sr", k),  b_sr,  k < 4);
      chk($sformatf("to%0d.err", k), b_err, k == 4);
      chk($sformatf("to%0d.cyc", k), bus_b.wishbone_cyc_o, 1);
      @(posedge clk) #1;
    end
    chk("to.cyc_drop", bus_b.wishbone_cyc_o, 0);
    chk("to.err_idle", b_err, 0);
    chk("to.cd_idle",  b_cd, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
